// File: rtl/remap_pkg.sv
// remap_pkg: shared types, defaults and tap indices for the bilinear remap engine
package remap_pkg;
  typedef enum logic {BORDER_CONST = 1'b0, BORDER_REPL = 1'b1} border_mode_e;
  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_HLERP, S_VLERP, S_OUT
  } state_e;
  localparam int FRAC_DEF = 12;
  localparam int WB_DEF = 8;
  localparam logic [1:0] TAP00 = 2'd0;
  localparam logic [1:0] TAP01 = 2'd1;
  localparam logic [1:0] TAP10 = 2'd2;
  localparam logic [1:0] TAP11 = 2'd3;
endpackage

// File: rtl/remap_bilerp_ch.sv
// remap_bilerp_ch: one-channel bilinear blend, horizontal then vertical pass with round-half-up
module remap_bilerp_ch #(
  parameter int DATA_W = 8,
  parameter int WB = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hl_en_i,
  input  logic              vl_en_i,
  input  logic [WB-1:0]     fx_i,
  input  logic [WB-1:0]     fy_i,
  input  logic [DATA_W-1:0] p00_i,
  input  logic [DATA_W-1:0] p01_i,
  input  logic [DATA_W-1:0] p10_i,
  input  logic [DATA_W-1:0] p11_i,
  output logic [DATA_W-1:0] pix_o
);
  localparam int TW = DATA_W + WB;
  localparam int VW = DATA_W + 2 * WB;
  localparam logic [WB:0] ONE = {1'b1, {WB{1'b0}}};
  localparam logic [VW-1:0] RND = {{DATA_W{1'b0}}, 1'b1, {(2 * WB - 1){1'b0}}};
  logic [WB:0] wx, wy;
  logic [TW-1:0] top_q, bot_q, top_d, bot_d;
  logic [VW-1:0] acc;
  logic [DATA_W-1:0] pix_q, pix_d;
  always_comb begin
    wx = ONE - {1'b0, fx_i};
    wy = ONE - {1'b0, fy_i};
    top_d = TW'(p00_i) * TW'(wx) + TW'(p01_i) * TW'(fx_i);
    bot_d = TW'(p10_i) * TW'(wx) + TW'(p11_i) * TW'(fx_i);
    acc = VW'(top_q) * VW'(wy) + VW'(bot_q) * VW'(fy_i) + RND;
    pix_d = DATA_W'(acc >> (2 * WB));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      bot_q <= '0;
      pix_q <= '0;
    end else begin
      if (hl_en_i) begin
        top_q <= top_d;
        bot_q <= bot_d;
      end
      if (vl_en_i) pix_q <= pix_d;
    end
  end
  assign pix_o = pix_q;
endmodule

// File: rtl/remap_bilinear.sv
// remap_bilinear: frame RAM plus fixed-latency bilinear sampler for signed fixed-point coordinates
module remap_bilinear
  import remap_pkg::*;
#(
  parameter int IMAGE_WIDTH = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FRAC = FRAC_DEF,
  parameter int COORD_W = 24,
  parameter int DATA_W = 8,
  parameter int CHANNELS = 1,
  parameter int WB = WB_DEF,
  parameter int ADDR_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_wr_en,
  input  logic [ADDR_W-1:0]            mem_wr_addr,
  input  logic [DATA_W*CHANNELS-1:0]   mem_wr_data,
  input  logic                         border_mode,
  input  logic [DATA_W-1:0]            border_value,
  input  logic                         map_valid,
  input  logic signed [COORD_W-1:0]    map_x,
  input  logic signed [COORD_W-1:0]    map_y,
  output logic                         map_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*CHANNELS-1:0]   out_pixel,
  output logic                         out_oob
);
  localparam int PW = DATA_W * CHANNELS;
  localparam int CW = COORD_W - FRAC + 1;
  localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic signed [CW-1:0] XW = CW'(IMAGE_WIDTH);
  localparam logic signed [CW-1:0] YH = CW'(IMAGE_HEIGHT);
  localparam logic signed [CW-1:0] XM = CW'(IMAGE_WIDTH - 1);
  localparam logic signed [CW-1:0] YM = CW'(IMAGE_HEIGHT - 1);
  state_e state_q;
  border_mode_e bm_q;
  logic [DATA_W-1:0] bv_q;
  logic signed [CW-1:0] x0_q, y0_q, rx, ry, cx, cy, kx, ky;
  logic [WB-1:0] fx_q, fy_q;
  logic map_ready_q, out_valid_q, out_oob_q;
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] rdata_q, cap_word;
  logic [PW-1:0] tap_q [4];
  logic [1:0] rd_idx, cap_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_en, cap_en, hl_en, vl_en, unused_ok;
  function automatic logic oob_f(input logic signed [CW-1:0] x, input logic signed [CW-1:0] y);
    return x[CW-1] || y[CW-1] || x >= XW || y >= YH;
  endfunction
  // Tap n is read in RDn and captured one state later, once the RAM output has settled
  always_comb begin
    rd_idx = 2'(state_q - S_RD0);
    cap_idx = 2'(state_q - S_RD1);
    rx = x0_q + CW'(rd_idx[0]);
    ry = y0_q + CW'(rd_idx[1]);
    cx = rx[CW-1] ? '0 : (rx >= XW ? XM : rx);
    cy = ry[CW-1] ? '0 : (ry >= YH ? YM : ry);
    rd_addr = ADDR_W'(cy) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(cx);
    rd_en = (state_q inside {S_RD0, S_RD1, S_RD2, S_RD3}) && !(bm_q == BORDER_CONST && oob_f(rx, ry));
    kx = x0_q + CW'(cap_idx[0]);
    ky = y0_q + CW'(cap_idx[1]);
    cap_en = state_q inside {S_RD1, S_RD2, S_RD3, S_WAIT};
    cap_word = (bm_q == BORDER_CONST && oob_f(kx, ky)) ? {CHANNELS{bv_q}} : rdata_q;
    hl_en = state_q == S_HLERP;
    vl_en = state_q == S_VLERP;
  end
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (rd_en) rdata_q <= mem[rd_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      map_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_oob_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
      fx_q <= '0;
      fy_q <= '0;
      bm_q <= BORDER_CONST;
      bv_q <= '0;
      for (int i = 0; i < 4; i++) tap_q[i] <= '0;
    end else if (state_q == S_IDLE) begin
      if (map_valid) begin
        state_q <= S_RD0;
        map_ready_q <= 1'b0;
        x0_q <= {map_x[COORD_W-1], map_x[COORD_W-1:FRAC]};
        y0_q <= {map_y[COORD_W-1], map_y[COORD_W-1:FRAC]};
        fx_q <= map_x[FRAC-1 -: WB];
        fy_q <= map_y[FRAC-1 -: WB];
        bm_q <= border_mode_e'(border_mode);
        bv_q <= border_value;
      end
    end else if (state_q == S_OUT) begin
      if (out_ready) begin
        state_q <= S_IDLE;
        map_ready_q <= 1'b1;
        out_valid_q <= 1'b0;
      end
    end else begin
      state_q <= state_e'(state_q + 4'd1);
      if (cap_en) tap_q[cap_idx] <= cap_word;
      if (state_q == S_VLERP) begin
        out_valid_q <= 1'b1;
        out_oob_q <= oob_f(x0_q, y0_q);
      end
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    remap_bilerp_ch #(.DATA_W(DATA_W), .WB(WB)) u_ch (
      .clk(clk),
      .rst(rst),
      .hl_en_i(hl_en),
      .vl_en_i(vl_en),
      .fx_i(fx_q),
      .fy_i(fy_q),
      .p00_i(tap_q[TAP00][c*DATA_W +: DATA_W]),
      .p01_i(tap_q[TAP01][c*DATA_W +: DATA_W]),
      .p10_i(tap_q[TAP10][c*DATA_W +: DATA_W]),
      .p11_i(tap_q[TAP11][c*DATA_W +: DATA_W]),
      .pix_o(out_pixel[c*DATA_W +: DATA_W])
    );
  end
  assign unused_ok = ^{map_x, map_y};
  assign map_ready = map_ready_q;
  assign out_valid = out_valid_q;
  assign out_oob = out_oob_q;
endmodule

// File: tb/tb_remap_bilinear.sv
// tb_remap_bilinear: directed and random checks of the sampler against an arithmetic model
module tb_remap_bilinear;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic we1 = 1'b0, we3 = 1'b0, mv1 = 1'b0, mv3 = 1'b0, bmode = 1'b0, ordy = 1'b1;
  logic [18:0] wa = '0;
  logic [23:0] wd = '0, mx_s = '0, my_s = '0;
  logic [7:0] bval = '0;
  logic mr1, ov1, oo1, mr3, ov3, oo3;
  logic [7:0] op1;
  logic [23:0] op3;
  logic [23:0] mem3 [128];
  int total = 0, bad = 0;

  remap_bilinear u_dut (
    .clk(clk), .rst(rst), .mem_wr_en(we1), .mem_wr_addr(wa), .mem_wr_data(wd[7:0]),
    .border_mode(bmode), .border_value(bval), .map_valid(mv1), .map_x(mx_s), .map_y(my_s),
    .map_ready(mr1), .out_valid(ov1), .out_ready(ordy), .out_pixel(op1), .out_oob(oo1)
  );
  remap_bilinear #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_wr_en(we3), .mem_wr_addr(wa[6:0]), .mem_wr_data(wd),
    .border_mode(bmode), .border_value(bval), .map_valid(mv3), .map_x(mx_s), .map_y(my_s),
    .map_ready(mr3), .out_valid(ov3), .out_ready(ordy), .out_pixel(op3), .out_oob(oo3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit oob_m(bit sel, int x, int y);
    return x < 0 || y < 0 || x >= (sel ? 16 : 640) || y >= (sel ? 8 : 480);
  endfunction

  // Frame 0 holds pixel[i] = i % 256; frame 1 holds random 3-channel words in mem3
  function automatic int tapv(bit sel, int x, int y, bit mode, int bv, int ch);
    int w, h, a;
    w = sel ? 16 : 640;
    h = sel ? 8 : 480;
    if (oob_m(sel, x, y) && !mode) return bv;
    x = x < 0 ? 0 : (x >= w ? w - 1 : x);
    y = y < 0 ? 0 : (y >= h ? h - 1 : y);
    a = y * w + x;
    return sel ? int'((mem3[a] >> (8 * ch)) & 24'hFF) : a % 256;
  endfunction

  function automatic int model(bit sel, int mx, int my, bit mode, int bv, int ch);
    int x0, y0, fx, fy, top, bot;
    x0 = mx >>> 12;
    y0 = my >>> 12;
    fx = (mx >>> 4) & 255;
    fy = (my >>> 4) & 255;
    top = tapv(sel, x0, y0, mode, bv, ch) * (256 - fx) + tapv(sel, x0 + 1, y0, mode, bv, ch) * fx;
    bot = tapv(sel, x0, y0 + 1, mode, bv, ch) * (256 - fx) + tapv(sel, x0 + 1, y0 + 1, mode, bv, ch) * fx;
    return (top * (256 - fy) + bot * fy + 32768) >>> 16;
  endfunction

  task automatic wr(input bit sel, input int a, input logic [23:0] d);
    @(negedge clk);
    we1 = !sel;
    we3 = sel;
    wa = 19'(a);
    wd = d;
    @(negedge clk);
    we1 = 1'b0;
    we3 = 1'b0;
  endtask

  task automatic run(input bit sel, input int mx, input int my, input bit mode, input logic [7:0] bv,
                     input bit rdy, output logic [23:0] pix, output logic oob, output int lat);
    if (!sel) begin
      for (int t = 0; t < 4; t++) begin
        int x, y;
        x = (mx >>> 12) + t % 2;
        y = (my >>> 12) + t / 2;
        x = x < 0 ? 0 : (x > 639 ? 639 : x);
        y = y < 0 ? 0 : (y > 479 ? 479 : y);
        wr(1'b0, y * 640 + x, 24'((y * 640 + x) % 256));
      end
    end
    @(negedge clk);
    mx_s = mx[23:0];
    my_s = my[23:0];
    bmode = mode;
    bval = bv;
    ordy = rdy;
    mv1 = !sel;
    mv3 = sel;
    @(negedge clk);
    mv1 = 1'b0;
    mv3 = 1'b0;
    lat = 1;
    while (!(sel ? ov3 : ov1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    pix = sel ? op3 : {16'h0, op1};
    oob = sel ? oo3 : oo1;
  endtask

  initial begin
    logic [23:0] pix;
    logic oob;
    int lat, cnt, mx, my, bv;
    bit mode;
    repeat (2) @(negedge clk);
    chk("rst_ready", mr1, 1);
    chk("rst_valid", ov1, 0);
    chk("rst_pixel", op1, 0);
    chk("rst_oob", oo1, 0);
    chk("rst_ready3", mr3, 1);
    chk("rst_valid3", ov3, 0);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem3[i] = 24'($urandom);
      wr(1'b1, i, mem3[i]);
    end
    run(1'b0, 159 << 12, 119 << 12, 1'b0, 8'h00, 1'b1, pix, oob, lat);
    chk("int_pix", pix, 31);
    chk("int_oob", oob, 0);
    chk("int_latency", lat, 8);
    run(1'b0, 43008, 0, 1'b0, 8'h00, 1'b1, pix, oob, lat);
    chk("half_10", pix, 11);
    run(1'b0, 255 * 4096 + 2048, 0, 1'b0, 8'h00, 1'b1, pix, oob, lat);
    chk("half_255", pix, 128);
    run(1'b0, -4096, 0, 1'b0, 8'h80, 1'b1, pix, oob, lat);
    chk("const_pix", pix, 8'h80);
    chk("const_oob", oob, 1);
    run(1'b0, -4096, 0, 1'b1, 8'h80, 1'b1, pix, oob, lat);
    chk("repl_pix", pix, 0);
    chk("repl_oob", oob, 1);
    run(1'b0, 639 * 4096 + 2048, 479 * 4096 + 2048, 1'b1, 8'h00, 1'b1, pix, oob, lat);
    chk("corner_pix", pix, 255);
    chk("corner_oob", oob, 0);
    run(1'b0, 43008, 0, 1'b0, 8'h00, 1'b0, pix, oob, lat);
    chk("bp_pix", pix, 11);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", ov1, 1);
      chk("bp_hold_pix", op1, 11);
      chk("bp_hold_ready", mr1, 0);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", ov1, 0);
    chk("bp_release_ready", mr1, 1);
    @(negedge clk);
    mx_s = 24'(159 << 12);
    my_s = 24'(119 << 12);
    bmode = 1'b0;
    mv1 = 1'b1;
    @(negedge clk);
    mv1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", ov1, 0);
    chk("abort_ready", mr1, 1);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov1) cnt++;
    end
    chk("abort_no_result", cnt, 0);
    chk("abort_ready_after", mr1, 1);
    run(1'b0, 159 << 12, 119 << 12, 1'b0, 8'h00, 1'b1, pix, oob, lat);
    chk("abort_retry_pix", pix, 31);
    chk("abort_retry_latency", lat, 8);
    for (int i = 0; i < 15; i++) begin
      mx = int'($urandom_range(0, 646 * 4096 - 1)) - 3 * 4096;
      my = int'($urandom_range(0, 486 * 4096 - 1)) - 3 * 4096;
      mode = 1'($urandom_range(0, 1));
      bv = int'($urandom_range(0, 255));
      run(1'b0, mx, my, mode, 8'(bv), 1'b1, pix, oob, lat);
      chk("rnd1_pix", pix, model(1'b0, mx, my, mode, bv, 0));
      chk("rnd1_oob", oob, oob_m(1'b0, mx >>> 12, my >>> 12));
      chk("rnd1_latency", lat, 8);
    end
    for (int i = 0; i < 20; i++) begin
      mx = int'($urandom_range(0, 20 * 4096 - 1)) - 2 * 4096;
      my = int'($urandom_range(0, 12 * 4096 - 1)) - 2 * 4096;
      mode = 1'($urandom_range(0, 1));
      bv = int'($urandom_range(0, 255));
      run(1'b1, mx, my, mode, 8'(bv), 1'b1, pix, oob, lat);
      for (int c = 0; c < 3; c++) chk($sformatf("rnd3_ch%0d", c), 32'(pix[8*c +: 8]), model(1'b1, mx, my, mode, bv, c));
      chk("rnd3_oob", oob, oob_m(1'b1, mx >>> 12, my >>> 12));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
